eth_arp_tx: RTL

Downstream TX stage for the packet-type arbiter. When the arbiter selects ARP, this block builds one ARP reply frame and streams it to the MAC TX port. The frame is 60 bytes, without FCS, on a 32-bit streaming interface. Its o_ready output is the arbiter's i_arp_ready. A rising edge on o_ready releases the arbiter back to PT_NONE.

---
 rtl/eth_defs.sv | 28 ++
 rtl/eth_arp_word_gen.sv | 39 +++
 rtl/eth_arp_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/eth_defs.sv
// Shared Ethernet/ARP constants and packet-type codes for the TX path.
// The arbiter and the per-type senders all import this package.
package eth_defs;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

    localparam int ETH_MIN_WORDS = 15;

    typedef enum logic [1:0] {
        PT_NONE = 2'd0,
        PT_ARP  = 2'd1,
        PT_ICMP = 2'd2,
        PT_UDP  = 2'd3
    } pt_e;

    typedef enum logic [1:0] {
        ARP_IDLE = 2'd0,
        ARP_SEND = 2'd1,
        ARP_GAP  = 2'd2
    } arp_tx_state_e;

endpackage

// File: rtl/eth_arp_word_gen.sv
// Maps a word index and the latched addresses to one 32-bit ARP frame word.
// The opcode is an input so a gratuitous-ARP sender can share this mapping.
module eth_arp_word_gen
    import eth_defs::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [15:0]      oper,
    input  logic [47:0]      self_mac,
    input  logic [31:0]      self_ip,
    input  logic [47:0]      req_mac,
    input  logic [31:0]      req_ip,
    output logic [31:0]      word
);

    logic [31:0] idx_s;

    // Big-endian word map: Ethernet header, ARP body, then zero padding.
    always_comb begin
        idx_s = 32'(idx);
        word  = 32'h0000_0000;
        case (idx_s)
            32'd0:   word = req_mac[47:16];
            32'd1:   word = {req_mac[15:0], self_mac[47:32]};
            32'd2:   word = self_mac[31:0];
            32'd3:   word = {ETHERTYPE_ARP, ARP_HTYPE_ETH};
            32'd4:   word = {ETHERTYPE_IPV4, ARP_HLEN_ETH, ARP_PLEN_IPV4};
            32'd5:   word = {oper, self_mac[47:32]};
            32'd6:   word = self_mac[31:0];
            32'd7:   word = self_ip;
            32'd8:   word = req_mac[47:16];
            32'd9:   word = {req_mac[15:0], req_ip[31:16]};
            32'd10:  word = {req_ip[15:0], 16'h0000};
            default: word = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/eth_arp_tx.sv
// ARP reply transmitter: builds one fixed-length frame per start pulse and
// streams it with valid/ready handshaking, then holds off for an inter-frame gap.
module eth_arp_tx
    import eth_defs::*;
#(
    parameter int FRAME_WORDS = ETH_MIN_WORDS,
    parameter int IFG_CYCLES  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic [47:0] i_req_mac,
    input  logic [31:0] i_req_ip,
    output logic        o_ready,
    output logic [31:0] o_data,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_vld,
    output logic [1:0]  o_empty,
    input  logic        i_rdy
);

    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    arp_tx_state_e    state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [GAP_W-1:0] gap_r;
    logic [47:0]      self_mac_r;
    logic [31:0]      self_ip_r;
    logic [47:0]      req_mac_r;
    logic [31:0]      req_ip_r;

    logic [CNT_W-1:0] gen_idx_s;
    logic [47:0]      gen_self_mac_s;
    logic [31:0]      gen_self_ip_s;
    logic [47:0]      gen_req_mac_s;
    logic [31:0]      gen_req_ip_s;
    logic [31:0]      gen_word_s;

    assign o_empty = 2'b00;

    // The generator looks one word ahead; in IDLE it reads the live inputs so W0 is ready on the start edge.
    always_comb begin
        if (state_r == ARP_IDLE) begin
            gen_idx_s      = '0;
            gen_self_mac_s = i_self_mac;
            gen_self_ip_s  = i_self_ip;
            gen_req_mac_s  = i_req_mac;
            gen_req_ip_s   = i_req_ip;
        end else begin
            gen_idx_s      = cnt_r + CNT_ONE;
            gen_self_mac_s = self_mac_r;
            gen_self_ip_s  = self_ip_r;
            gen_req_mac_s  = req_mac_r;
            gen_req_ip_s   = req_ip_r;
        end
    end

    eth_arp_word_gen #(
        .IDX_W (CNT_W)
    ) u_word_gen (
        .idx      (gen_idx_s),
        .oper     (ARP_OPER_REPLY),
        .self_mac (gen_self_mac_s),
        .self_ip  (gen_self_ip_s),
        .req_mac  (gen_req_mac_s),
        .req_ip   (gen_req_ip_s),
        .word     (gen_word_s)
    );

    // Frame FSM with registered stream outputs; cnt_r is the index of the word on o_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARP_IDLE;
            cnt_r      <= '0;
            gap_r      <= '0;
            self_mac_r <= 48'h0;
            self_ip_r  <= 32'h0;
            req_mac_r  <= 48'h0;
            req_ip_r   <= 32'h0;
            o_ready    <= 1'b1;
            o_vld      <= 1'b0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
            o_data     <= 32'h0;
        end else begin
            case (state_r)
                ARP_IDLE: begin
                    if (i_start) begin
                        self_mac_r <= i_self_mac;
                        self_ip_r  <= i_self_ip;
                        req_mac_r  <= i_req_mac;
                        req_ip_r   <= i_req_ip;
                        cnt_r      <= '0;
                        state_r    <= ARP_SEND;
                        o_ready    <= 1'b0;
                        o_vld      <= 1'b1;
                        o_sop      <= 1'b1;
                        o_eop      <= (LAST_IDX == '0);
                        o_data     <= gen_word_s;
                    end
                end
                ARP_SEND: begin
                    if (i_rdy) begin
                        if (cnt_r == LAST_IDX) begin
                            cnt_r  <= '0;
                            o_vld  <= 1'b0;
                            o_sop  <= 1'b0;
                            o_eop  <= 1'b0;
                            o_data <= 32'h0;
                            if (IFG_CYCLES > 0) begin
                                gap_r   <= '0;
                                state_r <= ARP_GAP;
                            end else begin
                                state_r <= ARP_IDLE;
                                o_ready <= 1'b1;
                            end
                        end else begin
                            cnt_r  <= cnt_r + CNT_ONE;
                            o_data <= gen_word_s;
                            o_sop  <= 1'b0;
                            o_eop  <= ((cnt_r + CNT_ONE) == LAST_IDX);
                        end
                    end
                end
                ARP_GAP: begin
                    if (gap_r == GAP_LAST) begin
                        gap_r   <= '0;
                        state_r <= ARP_IDLE;
                        o_ready <= 1'b1;
                    end else begin
                        gap_r <= gap_r + GAP_ONE;
                    end
                end
                default: begin
                    state_r <= ARP_IDLE;
                    cnt_r   <= '0;
                    gap_r   <= '0;
                    o_ready <= 1'b1;
                    o_vld   <= 1'b0;
                    o_sop   <= 1'b0;
                    o_eop   <= 1'b0;
                    o_data  <= 32'h0;
                end
            endcase
        end
    end

endmodule
